// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports, data first with a fetch starvation guard
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic [31:0]   d_rdata,
    output logic          d_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    state_t     state;
    logic [3:0] streak;
    logic       starve;
    logic       grant_d;
    assign starve  = i_req && streak == 4'(MAX_STREAK);
    assign grant_d = d_req && !starve;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            streak    <= 4'd0;
            busy      <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= 32'd0;
            d_rdata   <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_wstrb <= d_we ? d_wstrb : 4'd0;
                        streak    <= !i_req ? 4'd0 : (streak == 4'(MAX_STREAK)) ? streak : streak + 4'd1;
                        busy      <= 1'b1;
                        state     <= BUSY_D;
                    end else if (i_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wstrb <= 4'd0;
                        streak    <= 4'd0;
                        busy      <= 1'b1;
                        state     <= BUSY_I;
                    end else begin
                        mem_req <= 1'b0;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        i_rdata <= mem_rdata;
                        i_ack   <= 1'b1;
                        state   <= RESP;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        d_rdata <= mem_we ? d_rdata : mem_rdata;
                        d_ack   <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    // requests are deliberately not sampled here so a held request is not re-granted
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency, starvation guard and async reset
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_wstrb = 4'd0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        busy;
    int          n_chk = 0;
    int          n_err = 0;
    int          waits = 0;
    int          cnt = 0;
    int          grants = 0;
    int          acks = 0;
    logic        prev_req = 1'b0;
    logic [31:0] mem_val = 32'd0;

    mem_port_arbiter #(.AW(32), .MAX_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // memory answers after `waits` stall cycles and tolerates mem_req dropping
    always @(negedge clk) begin
        if (!rst_n || !mem_req) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (!mem_ack) begin
            if (cnt == waits) begin
                mem_ack = 1'b1;
                mem_rdata = mem_val;
            end else begin
                cnt++;
            end
        end
        if (mem_req && !prev_req) grants++;
        prev_req = mem_req;
        if (i_ack || d_ack) acks++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic is_d);
        int c;
        tick();
        c = 1;
        while (!(i_ack || d_ack) && c < 20) begin
            tick();
            c++;
        end
        chk("ack_timeout", 64'(i_ack || d_ack), 64'd1);
        chk("one_ack", 64'(i_ack && d_ack), 64'd0);
        is_d = d_ack;
    endtask

    initial begin
        logic       is_d;
        logic [9:0] seq;
        int         g0;
        int         a0;
        tick();
        tick();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_acks", 64'({i_ack, d_ack}), 64'd0);
        chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'd0);
        chk("rst_mem", 64'({mem_we, mem_addr, mem_wstrb}), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // single fetch, zero waits
        i_req = 1'b1; i_addr = 32'h100; mem_val = 32'h00500093; waits = 0;
        tick();
        chk("f_req", 64'({mem_req, mem_we, busy}), 64'b101);
        chk("f_addr", 64'(mem_addr), 64'h100);
        chk("f_noack", 64'({i_ack, d_ack}), 64'd0);
        tick();
        chk("f_ack", 64'({i_ack, d_ack, mem_req}), 64'b100);
        chk("f_rdata", 64'(i_rdata), 64'h00500093);
        i_req = 1'b0;
        tick();
        chk("f_idle", 64'({busy, i_ack, mem_req}), 64'd0);
        chk("f_addr_hold", 64'(mem_addr), 64'h100);

        // contention: load wins, fetch follows
        i_req = 1'b1; i_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wstrb = 4'hf; mem_val = 32'h11112222;
        tick();
        chk("c_grant_d", 64'({mem_req, mem_we, mem_wstrb}), 64'b1_0_0000);
        chk("c_addr_d", 64'(mem_addr), 64'h3000);
        tick();
        chk("c_dack", 64'({d_ack, i_ack}), 64'b10);
        chk("c_drdata", 64'(d_rdata), 64'h11112222);
        d_req = 1'b0; mem_val = 32'h33334444;
        tick();
        chk("c_idle", 64'({busy, mem_req}), 64'd0);
        tick();
        chk("c_grant_i", 64'({mem_req, mem_we}), 64'b10);
        chk("c_addr_i", 64'(mem_addr), 64'h104);
        tick();
        chk("c_iack", 64'({d_ack, i_ack}), 64'b01);
        chk("c_irdata", 64'(i_rdata), 64'h33334444);
        i_req = 1'b0;
        tick();

        // store with two wait cycles
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
        waits = 2; mem_val = 32'hBAD0BAD0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("s_hold%0d", k), 64'({mem_req, mem_we, mem_wstrb, d_ack}), 64'b1_1_0011_0);
            chk($sformatf("s_bus%0d", k), {mem_addr, mem_wdata}, {32'h2004, 32'hDEADBEEF});
        end
        tick();
        chk("s_ack", 64'({d_ack, mem_req}), 64'b10);
        chk("s_drdata", 64'(d_rdata), 64'h11112222);
        d_req = 1'b0; waits = 0;
        tick();

        // starvation guard: both held, expect 4 data grants then one fetch, repeated
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        seq = 10'b1111011110;
        for (int k = 0; k < 10; k++) begin
            wait_ack(is_d);
            chk($sformatf("starve%0d", k), 64'(is_d), 64'(seq[9-k]));
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // asynchronous reset during a data access
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; waits = 5;
        tick();
        chk("r_grant", 64'({mem_req, busy}), 64'b11);
        chk("r_addr", 64'(mem_addr), 64'h5000);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("r_async", 64'({mem_req, busy, i_ack, d_ack}), 64'd0);
        chk("r_clear", 64'({mem_addr, i_rdata}), 64'd0);
        d_req = 1'b0; waits = 0; mem_val = 32'h13579BDF;
        tick();
        rst_n = 1'b1;
        tick();
        chk("r_fetch", 64'({mem_req, mem_we, mem_wstrb}), 64'b1_0_0000);
        chk("r_faddr", 64'(mem_addr), 64'h300);
        wait_ack(is_d);
        chk("r_iack", 64'(is_d), 64'd0);
        chk("r_irdata", 64'(i_rdata), 64'h13579BDF);
        i_req = 1'b0;
        tick();

        // stale hold: request kept one cycle past ack is re-granted only from IDLE
        g0 = grants; a0 = acks;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6000; mem_val = 32'h2468ACE0;
        tick();
        chk("h_grant1", 64'(mem_req), 64'd1);
        tick();
        chk("h_ack1", 64'({d_ack, mem_req}), 64'b10);
        chk("h_rdata", 64'(d_rdata), 64'h2468ACE0);
        tick();
        chk("h_resp_block", 64'({mem_req, busy, d_ack}), 64'd0);
        tick();
        chk("h_grant2", 64'({mem_req, busy}), 64'b11);
        chk("h_addr2", 64'(mem_addr), 64'h6000);
        tick();
        chk("h_ack2", 64'(d_ack), 64'd1);
        d_req = 1'b0;
        tick();
        tick();
        chk("h_grants", 64'(grants - g0), 64'd2);
        chk("h_acks", 64'(acks - a0), 64'd2);
        chk("h_idle", 64'({busy, mem_req}), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the fetch stage (read-only instruction port) and the memory stage (load/store data port) of the pipelined RISC-V core.
- Uses req/ack handshakes on both sides and a tolerant-latency memory handshake.
- Gives fixed priority to the data port, plus a starvation guard so fetch still gets through.
- Fetch and memory-stage stall logic uses the two ack outputs.

Parameters:
- AW, 32, address width of all ports.
- MAX_STREAK, 4, consecutive data grants allowed while i_req is pending before fetch is forced; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  fetch read request; held with i_addr until i_ack
- i_addr  input  AW  fetch address
- i_rdata  output  32  fetched instruction
- i_ack  output  1  one-cycle completion pulse for fetch
- d_req  input  1  data request; held with d_we, d_addr, d_wdata, d_wstrb until d_ack
- d_we  input  1  1 = store, 0 = load
- d_addr  input  AW  data address
- d_wdata  input  32  store data
- d_wstrb  input  4  store byte enables
- d_rdata  output  32  load data
- d_ack  output  1  one-cycle completion pulse for data
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  AW  memory address
- mem_wdata  output  32  memory write data
- mem_wstrb  output  4  memory byte enables
- mem_rdata  input  32  memory read data, valid when mem_ack=1
- mem_ack  input  1  memory completion, sampled only while mem_req=1
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: state=IDLE, all mem_* outputs 0, i_rdata=0, d_rdata=0, i_ack=0, d_ack=0, streak=0, busy=0.
- All outputs are registered.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, grant decision:
  - if d_req and not (i_req and streak==MAX_STREAK): grant data;
  - else if i_req: grant fetch;
  - else stay in IDLE.
- On grant:
  - register the selected request into the mem_* outputs and set mem_req=1.
  - Fetch grant forces mem_we=0 and mem_wstrb=0.
  - Data load forces mem_wstrb=0.
  - Go to BUSY_D or BUSY_I.
- Streak counter, updated only on grants:
  - data grant with i_req=1: streak+1, saturating at MAX_STREAK;
  - data grant with i_req=0: streak=0;
  - fetch grant: streak=0.
- BUSY_x:
  - mem_* held stable until mem_ack.
  - On mem_ack: mem_req=0, go to RESP, and pulse x_ack next cycle.
  - For fetch, i_rdata<=mem_rdata. For a data load, d_rdata<=mem_rdata. For a store, d_rdata is unchanged.
- RESP:
  - exactly one of i_ack/d_ack is high for this single cycle.
  - Requests are not sampled, so a stale held request is never re-granted.
  - Go to IDLE.
- Requester contract: the requester may drop its request or present a new one at the edge where it sees ack.
- i_rdata/d_rdata hold their values until the next completion on the same port.
- Latency with a zero-wait memory (mem_ack in the first BUSY cycle):
  - request seen in IDLE at cycle 0 → mem_req at cycle 1 → ack at cycle 2 → IDLE at cycle 3;
  - 3 cycles per access. Each extra memory wait cycle adds 1.
- Simultaneous i_req and d_req in IDLE: data wins, unless the starvation rule applies.
- mem_ack outside BUSY: ignored.
- No request in IDLE: all mem_* outputs keep their last value, except mem_req=0.
- Reset mid-operation: immediate return to reset values; the in-flight memory access is abandoned and no ack is issued. The memory model must tolerate mem_req dropping.
- Acks are never issued to a port that was not granted. At most one ack is high per cycle.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100; memory returns 0x00500093 with 0 waits → mem_req at cycle 1 with mem_we=0; i_ack=1 and i_rdata=0x00500093 at cycle 2; d_ack=0 throughout.
- Store with waits: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=0b0011; 2 wait cycles → mem_* stable for 3 cycles; d_ack at cycle 4; d_rdata unchanged.
- Contention: i_req and d_req both high from cycle 0 with a load at 0x3000 → data granted first; fetch granted in the IDLE following the data RESP; two separate acks in order d then i.
- Starvation, MAX_STREAK=4: i_req held while d_req is re-asserted immediately after every d_ack → exactly 4 data grants, then a fetch grant, then streak=0 and data wins again.
- Reset mid-access: assert rst_n=0 asynchronously during BUSY_D, before mem_ack → mem_req, busy and all acks go to 0 immediately; after release, a pending i_req is granted normally.
- Stale hold: requester keeps d_req=1 with the same load for one cycle after d_ack → second grant occurs only from IDLE, proving RESP blocks re-sampling; completion count equals grant count.
